// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MAIN_CTRL_JUMP_EN to build the JUMP state; otherwise opcode 000010 traps.
module main_ctrl_fsm #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       pc_en,
  output logic [2:0] Aluop,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_TRAP
`ifdef MAIN_CTRL_JUMP_EN
    , S_JUMP
`endif
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       isLoad_q, isLoad_d;
  logic       isAndi_q, isAndi_d;
  logic       memStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      isLoad_q <= 1'b0;
      isAndi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      isLoad_q <= isLoad_d;
      isAndi_q <= isAndi_d;
    end
  end

  // The wait counter only survives while stalling inside a memory state, so it
  // is zero on entry to every memory state; mem_ready beats the timeout.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    isLoad_d   = isLoad_q;
    isAndi_d   = isAndi_q;
    memStall   = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    pc_en      = 1'b0;
    Aluop      = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        Aluop    = 3'b010;
        IRWrite  = mem_ready;
        pc_en    = mem_ready;
        memStall = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB  = 2'b11;
        Aluop    = 3'b010;
        isLoad_d = (Op == OP_LW);
        isAndi_d = (Op == OP_ANDI);
        case (Op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
`ifdef MAIN_CTRL_JUMP_EN
          OP_J:             state_d = S_JUMP;
`else
          OP_J:             state_d = S_TRAP;
`endif
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Aluop   = isLoad_q ? 3'b001 : 3'b010;
        state_d = isLoad_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        memStall = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        memStall   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        Aluop   = 3'b000;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        Aluop      = 3'b110;
        PCSource   = 2'b01;
        pc_en      = Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Aluop   = isAndi_q ? 3'b011 : 3'b010;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MAIN_CTRL_JUMP_EN
      S_JUMP: begin
        PCSource   = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    if (memStall && !mem_ready) begin
      if (wait_q == WAIT_LAST) state_d = S_TRAP;
      else wait_d = wait_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: per-cycle expected outputs are queued
// with their stimulus and compared as the DUT steps through each instruction.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       pc_en;
  logic [2:0] Aluop;
  logic       instr_done, illegal;
  logic [17:0] outVec;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        mr;
    logic        z;
    logic [17:0] exp;
    string       tag;
  } entry_t;

  entry_t expQ[$];

  main_ctrl_fsm #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .pc_en(pc_en), .Aluop(Aluop),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outVec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, PCSource, pc_en, Aluop, instr_done, illegal};

  // Packs one cycle's expected outputs in the same order as outVec.
  function automatic logic [17:0] pk(input logic iord, mrd, mwr, irw, rdst, m2r, rw, asa,
                                     input logic [1:0] asb, pcs, input logic pce,
                                     input logic [2:0] aop, input logic done, ill);
    return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, pce, aop, done, ill};
  endfunction

  function automatic logic [17:0] fetchVec(input logic mr);
    return pk(0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, mr, 3'b010, 0, 0);
  endfunction

  function automatic logic [17:0] trapVec();
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [17:0] observed, input logic [17:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  task automatic pushCycle(input string tag, input logic r, input logic [5:0] op,
                           input logic mr, input logic z, input logic [17:0] e);
    entry_t ent;
    ent.r = r; ent.op = op; ent.mr = mr; ent.z = z; ent.exp = e; ent.tag = tag;
    expQ.push_back(ent);
  endtask

  task automatic pushFront(input string nm, input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) pushCycle({nm, "_fetchWait"}, 0, op, 0, 1, fetchVec(0));
    pushCycle({nm, "_fetch"}, 0, op, 1, 1, fetchVec(1));
    pushCycle({nm, "_decode"}, 0, op, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
  endtask

  task automatic pushR(input int fetchWaits);
    pushFront("rtype", 6'b000000, fetchWaits);
    pushCycle("rtype_exec", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("rtype_rwb", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
  endtask

  task automatic pushLw(input int waits);
    pushFront("lw", 6'b100011, 0);
    pushCycle("lw_memadr", 0, 6'b100011, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b001, 0, 0));
    for (int i = 0; i < waits; i++)
      pushCycle("lw_memrdWait", 0, 6'b100011, 0, 1, pk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("lw_memrd", 0, 6'b100011, 1, 1, pk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("lw_memwb", 0, 6'b100011, 1, 1, pk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
  endtask

  task automatic pushSwHead();
    pushFront("sw", 6'b101011, 0);
    pushCycle("sw_memadr", 0, 6'b101011, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0));
  endtask

  task automatic pushSw(input int waits);
    pushSwHead();
    for (int i = 0; i < waits; i++)
      pushCycle("sw_memwrWait", 0, 6'b101011, 0, 1, pk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("sw_memwr", 0, 6'b101011, 1, 1, pk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
  endtask

  task automatic pushBeq(input logic z);
    pushFront("beq", 6'b000100, 0);
    pushCycle("beq_branch", 0, 6'b000100, 1, z, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, 3'b110, 1, 0));
  endtask

  task automatic pushImm(input logic isAndi);
    logic [5:0] op;
    op = isAndi ? 6'b001100 : 6'b001000;
    pushFront("imm", op, 0);
    pushCycle("imm_iexec", 0, op, 1, 1,
              pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, isAndi ? 3'b011 : 3'b010, 0, 0));
    pushCycle("imm_iwb", 0, op, 1, 1, pk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
  endtask

  task automatic pushTrapThenReset(input string nm, input int trapCycles);
    for (int i = 0; i < trapCycles; i++) pushCycle({nm, "_trap"}, 0, 6'b111111, 0, 1, trapVec());
    pushCycle({nm, "_trapRst"}, 1, 6'b111111, 0, 1, trapVec());
    pushCycle({nm, "_afterRst"}, 0, 6'b000000, 0, 1, fetchVec(0));
  endtask

  // Drives each queued cycle on the falling edge and checks outputs just after.
  task automatic applyStimulus();
    entry_t ent;
    while (expQ.size() > 0) begin
      ent = expQ.pop_front();
      @(negedge clk);
      rst = ent.r; Op = ent.op; mem_ready = ent.mr; Zero = ent.z;
      #1;
      checkOutput(ent.tag, outVec, ent.exp);
    end
  endtask

  initial begin
    rst = 1'b1; Op = 6'b000000; mem_ready = 1'b1; Zero = 1'b0;
    @(posedge clk);
    #1;

    pushR(0);
    pushLw(3);
    pushSw(2);
    pushBeq(1'b1);
    pushBeq(1'b0);
    pushImm(1'b1);
    pushImm(1'b0);
    applyStimulus();

    // Ready arrives on the last waiting cycle before the timeout would fire.
    pushR(14);
`ifdef MAIN_CTRL_JUMP_EN
    pushFront("jump", 6'b000010, 0);
    pushCycle("jump_exec", 0, 6'b000010, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b000, 1, 0));
    pushR(0);
`else
    pushFront("jump", 6'b000010, 0);
    pushTrapThenReset("jumpOff", 2);
    pushCycle("jumpOff_fetch", 0, 6'b000000, 1, 1, fetchVec(1));
    pushCycle("jumpOff_decode", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
    pushCycle("jumpOff_exec", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("jumpOff_rwb", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
`endif
    applyStimulus();

    pushFront("illegalOp", 6'b111111, 0);
    pushTrapThenReset("illegalOp", 20);
    pushCycle("illegalOp_fetch", 0, 6'b000000, 1, 1, fetchVec(1));
    pushCycle("illegalOp_decode", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
    pushCycle("illegalOp_exec", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("illegalOp_rwb", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
    applyStimulus();

    // Fetch timeout: 15 stalled cycles, TRAP on the 16th.
    for (int i = 0; i < 15; i++) pushCycle("fetchTimeout_wait", 0, 6'b000000, 0, 1, fetchVec(0));
    pushTrapThenReset("fetchTimeout", 3);
    pushCycle("fetchTimeout_fetch", 0, 6'b000000, 1, 1, fetchVec(1));
    pushCycle("fetchTimeout_decode", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
    pushCycle("fetchTimeout_exec", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("fetchTimeout_rwb", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
    applyStimulus();

    // Reset while a store is waiting in MEMWR.
    pushSwHead();
    pushCycle("swRst_memwrWait", 0, 6'b101011, 0, 1, pk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("swRst_memwrRst", 1, 6'b101011, 0, 1, pk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("swRst_afterRst", 0, 6'b000000, 0, 1, fetchVec(0));
    pushR(0);
    applyStimulus();

    // MEMRD timeout traps after 15 stalled cycles.
    pushFront("lwTimeout", 6'b100011, 0);
    pushCycle("lwTimeout_memadr", 0, 6'b100011, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b001, 0, 0));
    for (int i = 0; i < 15; i++)
      pushCycle("lwTimeout_wait", 0, 6'b100011, 0, 1, pk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushTrapThenReset("lwTimeout", 2);
    pushCycle("lwTimeout_fetch", 0, 6'b000000, 1, 1, fetchVec(1));
    pushCycle("lwTimeout_decode", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
    pushCycle("lwTimeout_exec", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0));
    pushCycle("lwTimeout_rwb", 0, 6'b000000, 1, 1, pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 1, 0));
    pushLw(0);
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
